// File: rtl/kme_chk_pkg.sv
// Shared definitions for the KME AXI-stream beat checker.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package kme_chk_pkg;

    // Observed tuser framing codes
    localparam logic [7:0] TU_SOT = 8'h01;
    localparam logic [7:0] TU_EOT = 8'h02;
    localparam logic [7:0] TU_MID = 8'h03;

    // Framing state tracked from the observed stream
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_STATS = 2'd2
    } chk_state_e;

    // Bit positions inside the per-beat mismatch mask
    localparam int MM_TDATA = 0;
    localparam int MM_TUSER = 1;
    localparam int MM_TSTRB = 2;
    localparam int MM_TLAST = 3;
    localparam int MM_TID   = 4;
    localparam int MM_PROTO = 5;
    localparam int MM_W     = 6;

endpackage

// File: rtl/kme_chk_fifo.sv
// Synchronous FIFO holding expected beats, with occupancy output.
// Latency: written entry is visible at the head the cycle after the push.
// Backpressure: writes refused while full; a same-cycle read does not free a slot for the write.
module kme_chk_fifo
    import kme_chk_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_full,
    input  logic             i_rd_rdy,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign o_rd_vld = (r_level != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_level  = r_level;
    assign w_push   = i_wr_vld & ~o_full;
    assign w_pop    = i_rd_rdy & o_rd_vld;

    // Storage array; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    // Pointer and occupancy tracking; reset flushes the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/kme_axis_stream_checker.sv
// Compares the observed KME outbound AXI-stream against queued expected beats; reports masks, counts, framing errors, stalls.
// Latency: check results, counters and flags update 1 cycle after the observed handshake.
// Backpressure: ob_tready only while enabled and an expected beat is queued; exp_tready drops when the queue is full.
module kme_axis_stream_checker
    import kme_chk_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned USER_W     = 8,
    parameter int unsigned TID_W      = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 10000,
    parameter logic [7:0]  STATS_TYPE = 8'h08,
    localparam int unsigned TSTRB_W   = DATA_W / 8,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               chk_en,
    input  logic               chk_clear,
    input  logic               exp_tvalid,
    output logic               exp_tready,
    input  logic [DATA_W-1:0]  exp_tdata,
    input  logic [TSTRB_W-1:0] exp_tstrb,
    input  logic [USER_W-1:0]  exp_tuser,
    input  logic [TID_W-1:0]   exp_tid,
    input  logic               exp_tlast,
    input  logic               ob_tvalid,
    output logic               ob_tready,
    input  logic [DATA_W-1:0]  ob_tdata,
    input  logic [TSTRB_W-1:0] ob_tstrb,
    input  logic [USER_W-1:0]  ob_tuser,
    input  logic [TID_W-1:0]   ob_tid,
    input  logic               ob_tlast,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               first_err_vld,
    output logic [MM_W-1:0]    first_err_mask,
    output logic [CNT_W-1:0]   first_err_beat,
    output logic               wdog_expired,
    output logic [LVL_W-1:0]   fifo_level
);

    localparam int unsigned       BEAT_W   = DATA_W + TSTRB_W + USER_W + TID_W + 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    logic [BEAT_W-1:0]  w_exp_beat;
    logic [BEAT_W-1:0]  w_head_beat;
    logic [DATA_W-1:0]  w_h_tdata;
    logic [TSTRB_W-1:0] w_h_tstrb;
    logic [USER_W-1:0]  w_h_tuser;
    logic [TID_W-1:0]   w_h_tid;
    logic               w_h_tlast;
    logic               w_full;
    logic               w_head_vld;
    logic               w_push;
    logic               w_hs;
    logic               w_is_sot;
    logic               w_is_eot;
    logic               w_is_mid;
    logic [MM_W-1:0]    w_mask;
    chk_state_e         r_state;
    chk_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_first_vld;
    logic [MM_W-1:0]    r_first_mask;
    logic [CNT_W-1:0]   r_first_beat;
    logic [WDOG_W-1:0]  r_wdog_cnt;
    logic               r_wdog_expired;

    assign w_exp_beat = {exp_tid, exp_tlast, exp_tstrb, exp_tuser, exp_tdata};
    assign {w_h_tid, w_h_tlast, w_h_tstrb, w_h_tuser, w_h_tdata} = w_head_beat;

    assign exp_tready = ~w_full;
    assign w_push     = exp_tvalid & ~w_full;
    assign ob_tready  = chk_en & w_head_vld;
    assign w_hs       = ob_tvalid & ob_tready;

    assign w_is_sot = (ob_tuser == USER_W'(TU_SOT));
    assign w_is_eot = (ob_tuser == USER_W'(TU_EOT));
    assign w_is_mid = (ob_tuser == USER_W'(TU_MID));

    kme_chk_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_push),
        .i_wr_dat (w_exp_beat),
        .o_full   (w_full),
        .i_rd_rdy (w_hs),
        .o_rd_vld (w_head_vld),
        .o_rd_dat (w_head_beat),
        .o_level  (fifo_level)
    );

    // Per-field compare of the observed beat against the queue head; case-equality so X counts as a mismatch
    always_comb begin
        w_mask           = '0;
        w_mask[MM_TDATA] = (ob_tdata !== w_h_tdata) && !((r_state == ST_STATS) && w_is_eot);
        w_mask[MM_TUSER] = (ob_tuser !== w_h_tuser);
        w_mask[MM_TSTRB] = (ob_tstrb !== w_h_tstrb);
        w_mask[MM_TLAST] = (ob_tlast !== w_h_tlast);
        w_mask[MM_TID]   = (ob_tid   !== w_h_tid);
        w_mask[MM_PROTO] = (r_state == ST_IDLE) ? (w_is_mid | w_is_eot) : w_is_sot;
    end

    // Framing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Framing next-state: SoT always (re)starts a frame, the expected header picks stats vs. data
    always_comb begin
        w_state_nxt = r_state;
        if (chk_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_hs) begin
            if (w_is_sot)      w_state_nxt = (w_h_tdata[7:0] == STATS_TYPE) ? ST_STATS : ST_FRAME;
            else if (w_is_eot) w_state_nxt = ST_IDLE;
        end
    end

    // Saturating beat/frame/error counters and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_first_vld  <= 1'b0;
            r_first_mask <= '0;
            r_first_beat <= '0;
        end else if (chk_clear) begin
            r_err_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_first_vld  <= 1'b0;
            r_first_mask <= '0;
            r_first_beat <= '0;
        end else if (w_hs) begin
            if (~&r_beat_cnt)              r_beat_cnt  <= r_beat_cnt + 1'b1;
            if (w_is_eot && ~&r_frame_cnt) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (|w_mask) begin
                if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_mask <= w_mask;
                    r_first_beat <= r_beat_cnt;
                end
            end
        end
    end

    // Stall watchdog: counts enabled cycles with a queued beat but no handshake, holds at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt     <= '0;
            r_wdog_expired <= 1'b0;
        end else if (chk_clear) begin
            r_wdog_cnt     <= '0;
            r_wdog_expired <= 1'b0;
        end else if (w_hs || !w_head_vld) begin
            r_wdog_cnt     <= '0;
        end else if (chk_en && (r_wdog_cnt != WDOG_MAX)) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
            if (r_wdog_cnt == WDOG_MAX - 1'b1) r_wdog_expired <= 1'b1;
        end
    end

    assign err_cnt        = r_err_cnt;
    assign beat_cnt       = r_beat_cnt;
    assign frame_cnt      = r_frame_cnt;
    assign first_err_vld  = r_first_vld;
    assign first_err_mask = r_first_mask;
    assign first_err_beat = r_first_beat;
    assign wdog_expired   = r_wdog_expired;

endmodule

// File: tb/tb_kme_axis_stream_checker.sv
// Self-checking bench for kme_axis_stream_checker: vector table plus scoreboard of expected counter state.
// Latency: scoreboard entries compared one cycle after each observed handshake.
// Backpressure: bench only drives ob beats while ob_tready is expected high.
module tb_kme_axis_stream_checker;

    localparam int DATA_W     = 64;
    localparam int USER_W     = 8;
    localparam int TID_W      = 1;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;
    localparam int WDOG_W     = 16;
    localparam int WDOG_LIMIT = 10000;
    localparam int TSTRB_W    = DATA_W / 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] SOT = 8'h01;
    localparam logic [7:0] EOT = 8'h02;
    localparam logic [7:0] MID = 8'h03;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               chk_en = 1'b0;
    logic               chk_clear = 1'b0;
    logic               exp_tvalid = 1'b0;
    logic               exp_tready;
    logic [DATA_W-1:0]  exp_tdata = '0;
    logic [TSTRB_W-1:0] exp_tstrb = '1;
    logic [USER_W-1:0]  exp_tuser = '0;
    logic [TID_W-1:0]   exp_tid = '0;
    logic               exp_tlast = 1'b0;
    logic               ob_tvalid = 1'b0;
    logic               ob_tready;
    logic [DATA_W-1:0]  ob_tdata = '0;
    logic [TSTRB_W-1:0] ob_tstrb = '1;
    logic [USER_W-1:0]  ob_tuser = '0;
    logic [TID_W-1:0]   ob_tid = '0;
    logic               ob_tlast = 1'b0;
    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   frame_cnt;
    logic               first_err_vld;
    logic [5:0]         first_err_mask;
    logic [CNT_W-1:0]   first_err_beat;
    logic               wdog_expired;
    logic [LVL_W-1:0]   fifo_level;

    always #5 clk = ~clk;

    kme_axis_stream_checker #(
        .DATA_W(DATA_W), .USER_W(USER_W), .TID_W(TID_W), .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W), .WDOG_W(WDOG_W), .WDOG_LIMIT(WDOG_LIMIT), .STATS_TYPE(8'h08)
    ) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .chk_clear(chk_clear),
        .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tdata(exp_tdata),
        .exp_tstrb(exp_tstrb), .exp_tuser(exp_tuser), .exp_tid(exp_tid), .exp_tlast(exp_tlast),
        .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata), .ob_tstrb(ob_tstrb),
        .ob_tuser(ob_tuser), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt), .frame_cnt(frame_cnt),
        .first_err_vld(first_err_vld), .first_err_mask(first_err_mask),
        .first_err_beat(first_err_beat), .wdog_expired(wdog_expired), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [7:0]  e_tuser;
        logic [63:0] e_tdata;
        logic        e_tlast;
        logic [7:0]  o_tuser;
        logic [63:0] o_tdata;
        logic [7:0]  o_tstrb_x;
        logic        o_tlast;
        logic        o_tid;
        logic [5:0]  mask;
    } vec_t;

    typedef struct {
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] beat;
        logic [CNT_W-1:0] frame;
        logic             fvld;
        logic [5:0]       fmask;
        logic [CNT_W-1:0] fbeat;
    } sb_t;

    vec_t vecs[17];
    sb_t  sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic mon_pend = 1'b0;

    logic [CNT_W-1:0] m_err, m_beat, m_frame, m_fbeat;
    logic             m_fvld;
    logic [5:0]       m_fmask;

    function automatic vec_t mk(input logic [7:0] et, input logic [63:0] ed, input logic el,
                                input logic [7:0] ot, input logic [63:0] od, input logic [7:0] sx,
                                input logic ol, input logic oi, input logic [5:0] m);
        vec_t v;
        v.e_tuser = et; v.e_tdata = ed; v.e_tlast = el;
        v.o_tuser = ot; v.o_tdata = od; v.o_tstrb_x = sx; v.o_tlast = ol; v.o_tid = oi;
        v.mask = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    endtask

    task automatic model_reset();
        m_err = '0; m_beat = '0; m_frame = '0; m_fbeat = '0; m_fvld = 1'b0; m_fmask = '0;
    endtask

    task automatic push_exp(input logic [7:0] tu, input logic [63:0] td, input logic tl);
        exp_tuser = tu; exp_tdata = td; exp_tlast = tl; exp_tstrb = '1; exp_tid = '0;
        exp_tvalid = 1'b1;
        @(posedge clk); #1;
        exp_tvalid = 1'b0;
    endtask

    task automatic drive_ob(input logic [7:0] tu, input logic [63:0] td, input logic [7:0] ts,
                            input logic tl, input logic ti, input logic [5:0] mask, input logic clr);
        sb_t r;
        chk("ob_tready_before_beat", ob_tready, 1'b1);
        ob_tuser = tu; ob_tdata = td; ob_tstrb = ts; ob_tlast = tl; ob_tid = ti;
        ob_tvalid = 1'b1; chk_clear = clr;
        if (clr) begin
            model_reset();
        end else begin
            if (mask != 6'b0) begin
                if (!m_fvld) begin
                    m_fvld = 1'b1; m_fmask = mask; m_fbeat = m_beat;
                end
                m_err = m_err + 1'b1;
            end
            if (tu == EOT) m_frame = m_frame + 1'b1;
            m_beat = m_beat + 1'b1;
        end
        r.err = m_err; r.beat = m_beat; r.frame = m_frame;
        r.fvld = m_fvld; r.fmask = m_fmask; r.fbeat = m_fbeat;
        sb_q.push_back(r);
        @(posedge clk); #1;
        ob_tvalid = 1'b0; chk_clear = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_exp(vecs[i].e_tuser, vecs[i].e_tdata, vecs[i].e_tlast);
        chk("fifo_level_filled", fifo_level, hi - lo + 1);
        for (int i = lo; i <= hi; i++)
            drive_ob(vecs[i].o_tuser, vecs[i].o_tdata, 8'hFF ^ vecs[i].o_tstrb_x,
                     vecs[i].o_tlast, vecs[i].o_tid, vecs[i].mask, 1'b0);
        settle();
    endtask

    task automatic do_clear();
        chk_clear = 1'b1;
        @(posedge clk); #1;
        chk_clear = 1'b0;
        model_reset();
        chk("clear_err_cnt", err_cnt, 0);
        chk("clear_beat_cnt", beat_cnt, 0);
        chk("clear_frame_cnt", frame_cnt, 0);
        chk("clear_first_err_vld", first_err_vld, 0);
        chk("clear_wdog", wdog_expired, 0);
    endtask

    // Scoreboard monitor: a handshake seen at one falling edge is checked at the next
    always @(negedge clk) begin
        sb_t r;
        if (mon_pend) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got unexpected beat, want none");
            end else begin
                r = sb_q.pop_front();
                chk("sb_err_cnt", err_cnt, r.err);
                chk("sb_beat_cnt", beat_cnt, r.beat);
                chk("sb_frame_cnt", frame_cnt, r.frame);
                chk("sb_first_err_vld", first_err_vld, r.fvld);
                chk("sb_first_err_mask", first_err_mask, r.fmask);
                chk("sb_first_err_beat", first_err_beat, r.fbeat);
            end
        end
        mon_pend = ob_tvalid & ob_tready & rst_n;
    end

    initial begin
        // Plain data frame
        vecs[0]  = mk(SOT, 64'h0A, 0, SOT, 64'h0A, 8'h00, 0, 0, 6'b000000);
        vecs[1]  = mk(MID, 64'h0B, 0, MID, 64'h0B, 8'h00, 0, 0, 6'b000000);
        vecs[2]  = mk(MID, 64'h0C, 0, MID, 64'h0C, 8'h00, 0, 0, 6'b000000);
        vecs[3]  = mk(EOT, 64'h0D, 1, EOT, 64'h0D, 8'h00, 1, 0, 6'b000000);
        // Stats frames: EoT data ignored, tstrb still checked
        vecs[4]  = mk(SOT, 64'h08, 0, SOT, 64'h08, 8'h00, 0, 0, 6'b000000);
        vecs[5]  = mk(MID, 64'h1234, 0, MID, 64'h1234, 8'h00, 0, 0, 6'b000000);
        vecs[6]  = mk(EOT, 64'h0, 1, EOT, 64'hDEAD, 8'h00, 1, 0, 6'b000000);
        vecs[7]  = mk(SOT, 64'h08, 0, SOT, 64'h08, 8'h00, 0, 0, 6'b000000);
        vecs[8]  = mk(EOT, 64'h0, 1, EOT, 64'hDEAD, 8'h01, 1, 0, 6'b000100);
        // Protocol and field errors
        vecs[9]  = mk(SOT, 64'h11, 0, SOT, 64'h11, 8'h00, 0, 0, 6'b000000);
        vecs[10] = mk(MID, 64'h22, 0, MID, 64'h22, 8'h00, 0, 0, 6'b000000);
        vecs[11] = mk(MID, 64'h33, 0, SOT, 64'h33, 8'h00, 0, 0, 6'b100010);
        vecs[12] = mk(EOT, 64'h44, 1, EOT, 64'h45, 8'h00, 1, 0, 6'b000001);
        vecs[13] = mk(EOT, 64'h55, 1, EOT, 64'h55, 8'h00, 1, 0, 6'b100000);
        vecs[14] = mk(SOT, 64'h20, 0, SOT, 64'h20, 8'h00, 0, 0, 6'b000000);
        vecs[15] = mk(MID, 64'h21, 0, MID, 64'h21, 8'h00, 0, 1, 6'b010000);
        vecs[16] = mk(EOT, 64'h22, 1, EOT, 64'h22, 8'h00, 0, 0, 6'b001000);

        model_reset();
        chk_en = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_first_err_vld", first_err_vld, 0);
        chk("rst_first_err_mask", first_err_mask, 0);
        chk("rst_first_err_beat", first_err_beat, 0);
        chk("rst_wdog", wdog_expired, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_exp_tready", exp_tready, 1);
        chk("rst_ob_tready", ob_tready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_rows(0, 3);
        run_rows(4, 8);
        do_clear();
        run_rows(9, 16);

        // Clear coincident with a handshake: beat popped, nothing counted
        push_exp(SOT, 64'h55, 0);
        drive_ob(SOT, 64'h99, 8'hFF, 0, 0, 6'b000001, 1'b1);
        settle();
        chk("clear_hs_fifo_level", fifo_level, 0);

        // Watchdog: disabled cycles do not count, expiry lands exactly at the limit
        chk_en = 1'b0;
        push_exp(SOT, 64'h01, 0);
        chk("wdog_ob_tready_disabled", ob_tready, 0);
        repeat (5) @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (WDOG_LIMIT - 1) @(posedge clk);
        @(negedge clk);
        chk("wdog_before_limit", wdog_expired, 0);
        @(posedge clk);
        @(negedge clk);
        chk("wdog_at_limit", wdog_expired, 1);
        do_clear();
        drive_ob(SOT, 64'h01, 8'hFF, 0, 0, 6'b000000, 1'b0);
        settle();
        do_clear();

        // Fill past depth with ob idle, then drain in order
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            exp_tuser  = (i == 0) ? SOT : ((i == FIFO_DEPTH - 1) ? EOT : MID);
            exp_tdata  = 64'h100 + 64'(i);
            exp_tlast  = (i == FIFO_DEPTH - 1);
            exp_tstrb  = '1;
            exp_tid    = '0;
            exp_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        exp_tvalid = 1'b0;
        @(negedge clk);
        chk("full_fifo_level", fifo_level, FIFO_DEPTH);
        chk("full_exp_tready", exp_tready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < FIFO_DEPTH; i++)
            drive_ob((i == 0) ? SOT : ((i == FIFO_DEPTH - 1) ? EOT : MID), 64'h100 + 64'(i),
                     8'hFF, (i == FIFO_DEPTH - 1), 0, 6'b000000, 1'b0);
        settle();
        chk("drained_fifo_level", fifo_level, 0);
        chk("drained_exp_tready", exp_tready, 1);

        // Async reset in the middle of a frame
        push_exp(SOT, 64'h21, 0);
        push_exp(MID, 64'h22, 0);
        push_exp(MID, 64'h23, 0);
        push_exp(EOT, 64'h24, 1);
        drive_ob(SOT, 64'h21, 8'hFF, 0, 0, 6'b000000, 1'b0);
        drive_ob(MID, 64'h22, 8'hFF, 0, 0, 6'b000000, 1'b0);
        settle();
        chk("midframe_fifo_level", fifo_level, 2);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("arst_fifo_level", fifo_level, 0);
        chk("arst_beat_cnt", beat_cnt, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_ob_tready", ob_tready, 0);
        chk("arst_exp_tready", exp_tready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_arst_ob_tready", ob_tready, 0);
        chk("post_arst_fifo_level", fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
